// File: rtl/btn_pkg.sv
// Shared constants for the push-button debounce bank: button indices, FSM state encoding and the
// counter-width helper used by every channel.
package btn_pkg;

    localparam int unsigned N_BTN = 5;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t LOW      = 2'd0;
    localparam btn_state_t CHK_HIGH = 2'd1;
    localparam btn_state_t HIGH     = 2'd2;
    localparam btn_state_t CHK_LOW  = 2'd3;

    // One counter serves both debounce and repeat timing, so size it for the longest interval.
    function automatic int unsigned cnt_width(input int unsigned debounce_cycles,
                                              input int unsigned repeat_delay,
                                              input int unsigned repeat_period);
        int unsigned m;
        m = debounce_cycles;
        if (repeat_delay > m) m = repeat_delay;
        if (repeat_period > m) m = repeat_period;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchroniser, four-state debounce FSM and, when BTN_AUTOREPEAT_EN is
// defined, the hold-to-repeat counter. Without the macro repeat_o is tied low.
module btn_debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic clock_100mhz,
    input  logic reset,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    // The cycle that enters a check state already saw the new value, so it counts as stable
    // cycle one; acceptance then lands DEBOUNCE_CYCLES edges after sync first shows it.
    localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 2);

    logic [1:0]      sync_q;
    logic            sync;
    btn_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept_hi, accept_lo;
    logic            level_q, press_q, release_q;

    assign sync = sync_q[1];

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw_i};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_hi = 1'b0;
        accept_lo = 1'b0;
        case (state_q)
            LOW: begin
                if (sync) begin
                    state_d = CHK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHK_HIGH: begin
                if (!sync) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == DbLast) begin
                    state_d   = HIGH;
                    cnt_d     = '0;
                    accept_hi = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!sync) begin
                    state_d = CHK_LOW;
                    cnt_d   = '0;
                end
            end
            CHK_LOW: begin
                if (sync) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == DbLast) begin
                    state_d   = LOW;
                    cnt_d     = '0;
                    accept_lo = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            state_q   <= LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= accept_hi;
            release_q <= accept_lo;
            if (accept_hi) begin
                level_q <= 1'b1;
            end else if (accept_lo) begin
                level_q <= 1'b0;
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CntW-1:0] RepFirstLast  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RepPeriodLast = CntW'(REPEAT_PERIOD - 1);

    logic [CntW-1:0] rcnt_q, rcnt_d;
    logic            rfirst_q, rfirst_d;
    logic            rep_fire;
    logic            repeat_q;

    always_comb begin
        rcnt_d   = rcnt_q;
        rfirst_d = rfirst_q;
        rep_fire = 1'b0;
        if (state_q == HIGH || state_q == CHK_LOW) begin
            if (rcnt_q == (rfirst_q ? RepFirstLast : RepPeriodLast)) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
                rfirst_d = 1'b0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
        // A repeat due on the release edge still fires; the counter restarts either way.
        if (accept_hi || accept_lo) begin
            rcnt_d   = '0;
            rfirst_d = 1'b1;
        end
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
            repeat_q <= rep_fire;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce_bank.sv
// Debounce and edge-detect bank for the five Basys3 buttons {btnD, btnR, btnL, btnU, btnC}.
// Auto-repeat is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clock_100mhz,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clock_100mhz (clock_100mhz),
            .reset        (reset),
            .btn_raw_i    (btn_raw[i]),
            .level_o      (btn_level[i]),
            .press_o      (btn_press[i]),
            .release_o    (btn_release[i]),
            .repeat_o     (btn_repeat[i])
        );
    end

endmodule
